sig_div_iter: RTL and testbench
===============================

SIG_DIV_ITER -- requirements
Module: sig_div_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 53, max significand width (incl. hidden bit).
REQ-002 SHALL have parameter RADIX_BITS, default 1, quotient bits per cycle; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  the reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port dividend  input  WIDTH  normalized significand, MSB of active precision set.
REQ-008 SHALL have port divisor  input  WIDTH  normalized significand, or zero.
REQ-009 SHALL have port db  input  1  1 = precision P=WIDTH, 0 = P=24, with operands right-aligned.
REQ-010 SHALL have port abort  input  1  discard the operation in flight.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port quotient  output  WIDTH+2  P+2 quotient bits, right-aligned; upper bits zero.
REQ-014 SHALL have port sticky  output  1  the final remainder OR the discarded quotient bits are nonzero.
REQ-015 SHALL have port div_by_zero  output  1  divisor was zero.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-017 SHALL accept operands and latch db on an edge with in_valid&&in_ready, moving IDLE->RUN.
REQ-018 SHALL perform restoring division with the remainder initialised to the dividend: per bit q=(R>=D), R=(R-q*D)<<1, MSB first.
REQ-019 SHALL use the iteration count N=ceil((P+2)/RADIX_BITS) and the cycle counter width $clog2(N+1).
REQ-020 SHALL make the Nth RUN edge transition to DONE, so out_valid rises exactly N edges after acceptance.
REQ-021 SHALL OR into sticky any surplus bits beyond P+2 produced when RADIX_BITS=2, and SHALL NOT place them in quotient.
REQ-022 SHALL have the remainder datapath WIDTH+2 bits wide, with no overflow for normalized inputs.
REQ-023 SHALL, when divisor==0 at acceptance, go IDLE->DONE in one edge with quotient all ones in the P+2 field, sticky=0, div_by_zero=1.
REQ-024 SHALL hold quotient, sticky and div_by_zero stable while out_valid=1 and out_ready=0.
REQ-025 SHALL go DONE->IDLE on an edge with out_ready=1; in_ready SHALL NOT be set in that same cycle, so no back-to-back accept occurs.
REQ-026 SHALL, on abort=1 in RUN or DONE, go to IDLE at the next edge with no result delivered; abort SHALL have priority over out_ready.
REQ-027 SHALL ignore abort in IDLE and SHALL ignore in_valid outside IDLE.
REQ-028 SHALL ignore operand changes during RUN, because operands are latched internally.

Reset
REQ-029 SHALL, on rst_n=0, immediately force state IDLE, counter 0, quotient 0, sticky 0, div_by_zero 0, out_valid 0 and in_ready 1 once released.
REQ-030 SHALL treat reset mid-RUN or mid-DONE as abort: the result is lost and no out_valid follows.

Structure
REQ-031 SHALL put the state enum (IDLE/RUN/DONE) and the constants SP_SIG_W=24 and DP_SIG_W=53 in a shared package, fpu_div_pkg.
REQ-032 SHALL place the 1- or 2-bit restoring step in the combinational sub-module sig_div_step, instantiated RADIX_BITS times in a chain.
REQ-033 SHALL keep the block instantiable in the existing multiplier/divider path, replacing the current fixed divider.

Verification
REQ-034 SHALL cover: WIDTH=53, RADIX_BITS=1, db=1, dividend=divisor=2^52 -> out_valid 55 edges after accept, quotient=2^54, sticky=0.
REQ-035 SHALL cover: db=0, dividend=0x800000, divisor=0xC00000 -> out_valid 26 edges after accept, quotient=0x1555555, sticky=1.
REQ-036 SHALL cover: RADIX_BITS=2, db=1, 1.0/1.0 -> out_valid 28 edges after accept, quotient=2^54, sticky=0.
REQ-037 SHALL cover: divisor=0, db=0 -> out_valid after 1 edge, quotient=0x3FFFFFF, div_by_zero=1.
REQ-038 SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-039 SHALL cover: rst_n pulsed low at RUN cycle 20, and separately abort=1 at RUN cycle 20 -> IDLE, no out_valid, and a new operation afterward gives a correct result.

Source files
------------

// File: rtl/fpu_div_pkg.sv
// rtl/fpu_div_pkg.sv - shared state encoding and significand widths for the FPU divider
package fpu_div_pkg;

    localparam int SP_SIG_W = 24;
    localparam int DP_SIG_W = 53;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/sig_div_step.sv
// rtl/sig_div_step.sv - one combinational restoring-division bit step
module sig_div_step #(
    parameter int WIDTH = 53
) (
    input  logic [WIDTH+1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH+1:0] rem_out,
    output logic             q
);

    logic [WIDTH+1:0] d_ext;
    logic [WIDTH+1:0] diff;

    assign d_ext   = {2'b00, divisor};
    assign q       = (rem_in >= d_ext);
    assign diff    = q ? (rem_in - d_ext) : rem_in;
    // R < 2D holds for normalized operands, so the shifted-out bit is always zero
    assign rem_out = diff << 1;

endmodule

// File: rtl/sig_div_iter.sv
// rtl/sig_div_iter.sv - iterative restoring significand divider, 1 or 2 quotient bits per cycle
module sig_div_iter
    import fpu_div_pkg::*;
#(
    parameter int WIDTH      = DP_SIG_W,
    parameter int RADIX_BITS = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             db,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH+1:0] quotient,
    output logic             sticky,
    output logic             div_by_zero
);

    localparam int RW     = WIDTH + 2;
    localparam int N_DP   = ceil_div(WIDTH + 2, RADIX_BITS);
    localparam int N_SP   = ceil_div(SP_SIG_W + 2, RADIX_BITS);
    localparam int CNT_W  = $clog2(N_DP + 1);
    localparam int QACC_W = N_DP * RADIX_BITS;

    localparam logic [CNT_W-1:0] LAST_DP = CNT_W'(N_DP - 1);
    localparam logic [CNT_W-1:0] LAST_SP = CNT_W'(N_SP - 1);
    localparam logic SURP_DP = ((N_DP * RADIX_BITS) != (WIDTH + 2));
    localparam logic SURP_SP = ((N_SP * RADIX_BITS) != (SP_SIG_W + 2));
    localparam logic [RW-1:0] ONES_DP = '1;
    localparam logic [RW-1:0] ONES_SP = {{(RW - SP_SIG_W - 2){1'b0}}, {(SP_SIG_W + 2){1'b1}}};

    div_state_e state, state_next;

    logic [CNT_W-1:0]      cnt;
    logic [RW-1:0]         rem;
    logic [WIDTH-1:0]      div_r;
    logic                  db_r;
    logic [QACC_W-1:0]     qacc;
    logic [QACC_W-1:0]     qacc_next;
    logic [RW-1:0]         quotient_r;
    logic                  sticky_r;
    logic                  dbz_r;
    logic [RW-1:0]         rem_chain [RADIX_BITS+1];
    logic [RADIX_BITS-1:0] step_q;
    logic                  is_last;
    logic                  surplus;

    assign rem_chain[0] = rem;

    // Step 0 produces the more significant bit of each cycle's group
    for (genvar i = 0; i < RADIX_BITS; i++) begin : g_step
        sig_div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in  (rem_chain[i]),
            .divisor (div_r),
            .rem_out (rem_chain[i+1]),
            .q       (step_q[RADIX_BITS-1-i])
        );
    end

    assign qacc_next = (qacc << RADIX_BITS) | QACC_W'(step_q);
    assign is_last   = (cnt == (db_r ? LAST_DP : LAST_SP));
    assign surplus   = db_r ? SURP_DP : SURP_SP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (is_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            rem        <= '0;
            div_r      <= '0;
            db_r       <= 1'b0;
            qacc       <= '0;
            quotient_r <= '0;
            sticky_r   <= 1'b0;
            dbz_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        db_r  <= db;
                        div_r <= divisor;
                        rem   <= RW'(dividend);
                        qacc  <= '0;
                        cnt   <= '0;
                        if (divisor == '0) begin
                            quotient_r <= db ? ONES_DP : ONES_SP;
                            sticky_r   <= 1'b0;
                            dbz_r      <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!abort) begin
                        rem  <= rem_chain[RADIX_BITS];
                        qacc <= qacc_next;
                        cnt  <= cnt + 1'b1;
                        // Radix-2 may overshoot P+2 bits by one; that bit only feeds sticky
                        if (is_last) begin
                            quotient_r <= RW'(qacc_next >> surplus);
                            sticky_r   <= (|rem_chain[RADIX_BITS]) | (surplus & qacc_next[0]);
                            dbz_r      <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quotient_r;
    assign sticky      = sticky_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_sig_div_iter.sv
// tb/tb_sig_div_iter.sv - directed self-checking bench for sig_div_iter (radix 1 and radix 2)
module tb_sig_div_iter;

    localparam int W = 53;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic          db;
    logic          abort;
    logic          out_ready;

    logic          ir1, ov1, st1, dz1;
    logic [W+1:0]  q1;
    logic          ir2, ov2, st2, dz2;
    logic [W+1:0]  q2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sig_div_iter #(.WIDTH(W), .RADIX_BITS(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .dividend(dividend), .divisor(divisor), .db(db), .abort(abort),
        .out_valid(ov1), .out_ready(out_ready), .quotient(q1),
        .sticky(st1), .div_by_zero(dz1)
    );

    sig_div_iter #(.WIDTH(W), .RADIX_BITS(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir2),
        .dividend(dividend), .divisor(divisor), .db(db), .abort(abort),
        .out_valid(ov2), .out_ready(out_ready), .quotient(q2),
        .sticky(st2), .div_by_zero(dz2)
    );

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic dbv, input logic [63:0] eq, input logic es,
                          input logic ed, input int lat1, input int lat2);
        int got1;
        int got2;
        dividend = a;
        divisor  = b;
        db       = dbv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        dividend = '1;
        divisor  = 53'h1;
        db       = ~dbv;
        got1 = -1;
        got2 = -1;
        for (int e = 0; e <= 100; e++) begin
            if (e > 0) tick();
            if (got1 < 0 && ov1) got1 = e;
            if (got2 < 0 && ov2) got2 = e;
            if (got1 >= 0 && got2 >= 0) break;
        end
        chk_eq({tag, " lat_r1"}, 64'(got1), 64'(lat1));
        chk_eq({tag, " lat_r2"}, 64'(got2), 64'(lat2));
        for (int c = 0; c < 10; c++) begin
            chk_eq({tag, " q_r1"}, 64'(q1), eq);
            chk_eq({tag, " q_r2"}, 64'(q2), eq);
            chk_eq({tag, " st_r1"}, 64'(st1), 64'(es));
            chk_eq({tag, " st_r2"}, 64'(st2), 64'(es));
            chk_eq({tag, " dz_r1"}, 64'(dz1), 64'(ed));
            chk_eq({tag, " dz_r2"}, 64'(dz2), 64'(ed));
            chk_eq({tag, " hold_ov"}, 64'({ov1, ov2, ir1, ir2}), 64'b1100);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_eq({tag, " release"}, 64'({ov1, ov2, ir1, ir2}), 64'b0011);
    endtask

    task automatic watch_silent(input string tag);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            seen = seen | ov1 | ov2;
        end
        chk_eq({tag, " no_out_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        db        = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk_eq("reset_flags", 64'({ir1, ir2, ov1, ov2, st1, st2, dz1, dz2}), 64'b1100_0000);
        chk_eq("reset_q_r1", 64'(q1), 64'd0);
        chk_eq("reset_q_r2", 64'(q2), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("dp_1_1",    53'h10000000000000, 53'h10000000000000, 1'b1,
               64'h40000000000000, 1'b0, 1'b0, 55, 28);
        run_op("sp_2_3",    53'h800000, 53'hC00000, 1'b0,
               64'h1555555, 1'b1, 1'b0, 26, 13);
        run_op("sp_div0",   53'h800000, 53'h0, 1'b0,
               64'h3FFFFFF, 1'b0, 1'b1, 0, 0);
        run_op("dp_3_2",    53'h18000000000000, 53'h10000000000000, 1'b1,
               64'h60000000000000, 1'b0, 1'b0, 55, 28);
        run_op("sp_3_2",    53'hC00000, 53'h800000, 1'b0,
               64'h3000000, 1'b0, 1'b0, 26, 13);
        run_op("dp_div0",   53'h10000000000000, 53'h0, 1'b1,
               64'h7FFFFFFFFFFFFF, 1'b0, 1'b1, 0, 0);
        run_op("sp_max",    53'hFFFFFF, 53'h800000, 1'b0,
               64'h3FFFFFC, 1'b0, 1'b0, 26, 13);
        run_op("dp_near",   53'h10000000000000, 53'h1FFFFFFFFFFFFF, 1'b1,
               64'h20000000000001, 1'b1, 1'b0, 55, 28);

        // Abort at RUN cycle 20
        dividend = 53'h10000000000000;
        divisor  = 53'h10000000000000;
        db       = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_eq("abort_idle", 64'({ov1, ov2, ir1, ir2}), 64'b0011);
        watch_silent("abort");
        run_op("after_abort", 53'h800000, 53'hC00000, 1'b0,
               64'h1555555, 1'b1, 1'b0, 26, 13);

        // Reset pulse at RUN cycle 20
        dividend = 53'h10000000000000;
        divisor  = 53'h10000000000000;
        db       = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        chk_eq("rst_mid_flags", 64'({ov1, ov2, ir1, ir2, st1, st2}), 64'b001100);
        chk_eq("rst_mid_q_r1", 64'(q1), 64'd0);
        chk_eq("rst_mid_q_r2", 64'(q2), 64'd0);
        tick();
        rst_n = 1'b1;
        watch_silent("reset");
        run_op("after_reset", 53'h10000000000000, 53'h10000000000000, 1'b1,
               64'h40000000000000, 1'b0, 1'b0, 55, 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
